lsf_input_scheduler: RTL and testbench
======================================

# lsf_input_scheduler

Time-multiplexes one Legendre segment-finder engine between `N_CH` hit-extraction (HEG) channels. Each channel presents a first-word-fall-through ROI FIFO and hit FIFO. The scheduler grants the engine to one channel at a time in round-robin order. For each event it forwards one ROI, then that event's hits, then pulses end-of-event, then waits for the engine result before granting the next channel. It sits between the per-station HEG output FIFOs and the LSF engine's ROI/hit read interfaces.

## Interface
Parameters:
- `N_CH`, 3: number of HEG channels sharing the engine.
- `ROI_W`, `HEG2SFSLC_LEN`: ROI word width.
- `HIT_W`, `HEG2SFHIT_LEN`: hit word width.
- `MAX_HITS`, 32: maximum hits forwarded per event.
- `HIT_TIMEOUT`, 16: consecutive empty-hit cycles that close an event window.
- `RESULT_TIMEOUT`, 255: maximum cycles waiting for the engine result.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `ch_roi`  in  `N_CH*ROI_W`  channel ROI heads; channel i occupies bits [i*ROI_W +: ROI_W].
- `ch_roi_empty`  in  `N_CH`  ROI FIFO empty flags.
- `ch_roi_re`  out  `N_CH`  ROI FIFO read enables.
- `ch_hit`  in  `N_CH*HIT_W`  channel hit heads.
- `ch_hit_empty`  in  `N_CH`  hit FIFO empty flags.
- `ch_hit_re`  out  `N_CH`  hit FIFO read enables.
- `le_roi`  out  `ROI_W`  ROI presented to the engine.
- `le_roi_empty`  out  1  engine-side ROI empty.
- `le_roi_re`  in  1  engine ROI read.
- `le_hit`  out  `HIT_W`  hit presented to the engine.
- `le_hit_empty`  out  1  engine-side hit empty.
- `le_hit_re`  in  1  engine hit read.
- `le_eof`  out  1  one-cycle end-of-event pulse (drives the engine's `i_eof`).
- `le_output_vld`  in  1  engine result valid.
- `busy`  out  1  scheduler not in IDLE.
- `active_ch`  out  `$clog2(N_CH)`  currently granted channel.
- `err_timeout`  out  1  one-cycle pulse when `RESULT_TIMEOUT` expires.
- `drop_cnt`  out  16  saturating count of hits discarded above `MAX_HITS`.

## Operation
States: IDLE, ROI, HITS, DRAIN, EOF, WAIT.

- **IDLE**
  - Search channels starting at `rr_ptr` (wrapping modulo `N_CH`) for the first one with `ch_roi_empty`=0.
  - Latch it into `sel`, then go to ROI.
  - If no channel has an ROI, stay in IDLE.
- **ROI**
  - `le_roi`=`ch_roi[sel]`; `le_roi_empty`=`ch_roi_empty[sel]`; `ch_roi_re[sel]`=`le_roi_re & ~le_roi_empty`.
  - On a completed read: clear `hit_cnt` and `idle_cnt`, go to HITS.
- **HITS**
  - Hit path is muxed the same way; `ch_hit_re[sel]`=`le_hit_re & ~le_hit_empty`.
  - Each forwarded hit increments `hit_cnt` and clears `idle_cnt`.
  - A cycle with `ch_hit_empty[sel]`=1 increments `idle_cnt`.
  - If `idle_cnt`=`HIT_TIMEOUT`-1 on an empty cycle, go to EOF.
  - If `hit_cnt` reaches `MAX_HITS`, go to DRAIN.
- **DRAIN**
  - `le_hit_empty`=1.
  - The scheduler asserts `ch_hit_re[sel]`=`~ch_hit_empty[sel]` itself. Each discarded hit increments `drop_cnt` (saturating at 0xFFFF) and clears `idle_cnt`.
  - Go to EOF on the `HIT_TIMEOUT` idle condition.
- **EOF**
  - `le_eof`=1 for exactly one cycle, then go to WAIT with `wait_cnt`=0.
- **WAIT**
  - `le_output_vld`=1: go to IDLE, `rr_ptr`=`sel`+1 mod `N_CH`.
  - `wait_cnt`=`RESULT_TIMEOUT`: pulse `err_timeout`, go to IDLE with the same pointer update.
- **All states:** outside ROI, `le_roi_empty`=1. Outside HITS, `le_hit_empty`=1. Only `sel` may have a read enable high, and only in ROI, HITS or DRAIN.
- **Counter widths:** `hit_cnt` is `$clog2(MAX_HITS+1)` bits, `idle_cnt` is `$clog2(HIT_TIMEOUT)` bits, `wait_cnt` is 8 bits. None of them wrap.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `sel`=0.
  - `busy`=0, `active_ch`=0, `le_eof`=0, `err_timeout`=0, `drop_cnt`=0.
  - All `ch_*_re`=0; `le_roi_empty`=1, `le_hit_empty`=1.
- Reset asserted mid-event forces these values on the next edge. No read enable is asserted during a reset cycle. The partial event is abandoned and no `le_eof` is issued.
- Latency and registering:
  - Grant takes 1 cycle: ROI visible at the engine the cycle after IDLE sees a non-empty ROI.
  - The read path (data, empty, read enable) is combinational through the mux, adding zero latency.
  - `le_eof`, `err_timeout`, `busy` and `active_ch` are registered.
- Boundary conditions:
  - `le_output_vld` arriving in any state other than WAIT is ignored.
  - `le_output_vld` and timeout expiring in the same cycle: result wins, no `err_timeout`.
  - A hit read in the same cycle that `idle_cnt` would expire resets `idle_cnt`; the window stays open.
  - A new ROI on a non-selected channel has no effect until IDLE.
  - `N_CH`=1 degenerates to sequential per-event operation.

## Test plan
- **Single event.** Channel 0: ROI plus 5 hits at 1 per cycle; engine reads continuously -> 1 ROI read and 5 hit reads. `le_eof` pulses `HIT_TIMEOUT` cycles after the last hit. `le_output_vld` 10 cycles later returns to IDLE with `rr_ptr`=1.
- **Round robin.** ROIs pending on channels 0, 1, 2 simultaneously -> grants in order 0, 1, 2. Then a re-arrival on channel 0 with 1 also pending grants 1 if `rr_ptr`=1.
- **Overflow.** Channel 1: 40 hits back-to-back with `MAX_HITS`=32 -> 32 hits forwarded, 8 discarded, `drop_cnt`=8, `le_hit_empty`=1 during DRAIN.
- **Result timeout.** Engine never asserts `le_output_vld` -> `err_timeout` pulses once, 256 cycles after entering WAIT; next channel granted.
- **Reset mid-HITS.** Assert reset after 3 of 6 hits -> all outputs at reset values the next cycle. No `le_eof`. Remaining 3 hits stay unread.
- **Empty-flag honouring.** `le_hit_re` held high while the channel hit FIFO is empty -> `ch_hit_re` stays 0 and `hit_cnt` unchanged.

Source files
------------

// File: rtl/lsf_input_scheduler.sv
// Round-robin scheduler that lends one Legendre segment-finder engine to N_CH
// hit-extraction channels, forwarding one ROI and its hits per event.
module lsf_input_scheduler #(
   parameter int N_CH           = 3,
   parameter int ROI_W          = 32,
   parameter int HIT_W          = 32,
   parameter int MAX_HITS       = 32,
   parameter int HIT_TIMEOUT    = 16,
   parameter int RESULT_TIMEOUT = 255,
   localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_CH*ROI_W-1:0]  ch_roi,
   input  logic [N_CH-1:0]        ch_roi_empty,
   output logic [N_CH-1:0]        ch_roi_re,
   input  logic [N_CH*HIT_W-1:0]  ch_hit,
   input  logic [N_CH-1:0]        ch_hit_empty,
   output logic [N_CH-1:0]        ch_hit_re,
   output logic [ROI_W-1:0]       le_roi,
   output logic                   le_roi_empty,
   input  logic                   le_roi_re,
   output logic [HIT_W-1:0]       le_hit,
   output logic                   le_hit_empty,
   input  logic                   le_hit_re,
   output logic                   le_eof,
   input  logic                   le_output_vld,
   output logic                   busy,
   output logic [CH_W-1:0]        active_ch,
   output logic                   err_timeout,
   output logic [15:0]            drop_cnt
);

   localparam int HC_W = $clog2(MAX_HITS + 1);
   localparam int IC_W = (HIT_TIMEOUT > 1) ? $clog2(HIT_TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ROI   = 3'd1;
   localparam logic [2:0] S_HITS  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_EOF   = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   localparam logic [HC_W-1:0] HIT_LAST  = HC_W'(MAX_HITS - 1);
   localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(HIT_TIMEOUT - 1);
   localparam logic [7:0]      WAIT_LAST = 8'(RESULT_TIMEOUT);
   localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);

   logic [2:0]      state_q, state_d;
   logic [CH_W-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d;
   logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            err_q, err_d, busy_q, eof_q;

   logic            sel_roi_empty, sel_hit_empty;
   logic            roi_take, hit_take, hit_drop, found;
   logic [CH_W-1:0] next_ch, sel_inc;

   // Read path is purely combinational; reset blocks every read enable in its cycle.
   always_comb begin
      sel_roi_empty = ch_roi_empty[sel_q];
      sel_hit_empty = ch_hit_empty[sel_q];
      le_roi        = ch_roi[sel_q*ROI_W +: ROI_W];
      le_hit        = ch_hit[sel_q*HIT_W +: HIT_W];
      le_roi_empty  = reset | (state_q != S_ROI) | sel_roi_empty;
      le_hit_empty  = reset | (state_q != S_HITS) | sel_hit_empty;
      roi_take      = le_roi_re & ~le_roi_empty;
      hit_take      = le_hit_re & ~le_hit_empty;
      hit_drop      = ~reset & (state_q == S_DRAIN) & ~sel_hit_empty;
      ch_roi_re        = '0;
      ch_hit_re        = '0;
      ch_roi_re[sel_q] = roi_take;
      ch_hit_re[sel_q] = hit_take | hit_drop;
   end

   // Descending scan so the channel closest to rr_ptr wins.
   always_comb begin
      found   = 1'b0;
      next_ch = rr_ptr_q;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (!ch_roi_empty[(int'(rr_ptr_q) + k) % N_CH]) begin
            found   = 1'b1;
            next_ch = CH_W'((int'(rr_ptr_q) + k) % N_CH);
         end
      end
      sel_inc = (sel_q == CH_LAST) ? '0 : sel_q + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      hit_cnt_d  = hit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      wait_cnt_d = wait_cnt_q;
      drop_cnt_d = drop_cnt_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               sel_d   = next_ch;
               state_d = S_ROI;
            end
         end
         S_ROI: begin
            if (roi_take) begin
               hit_cnt_d  = '0;
               idle_cnt_d = '0;
               state_d    = S_HITS;
            end
         end
         S_HITS: begin
            if (hit_take) begin
               hit_cnt_d  = hit_cnt_q + 1'b1;
               idle_cnt_d = '0;
               if (hit_cnt_q == HIT_LAST) state_d = S_DRAIN;
            end else if (sel_hit_empty) begin
               if (idle_cnt_q == IDLE_LAST) state_d = S_EOF;
               else idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (hit_drop) begin
               if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               state_d = S_EOF;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         S_EOF: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle beats the timeout.
            if (le_output_vld) begin
               state_d  = S_IDLE;
               rr_ptr_d = sel_inc;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d    = 1'b1;
               state_d  = S_IDLE;
               rr_ptr_d = sel_inc;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         rr_ptr_q   <= '0;
         hit_cnt_q  <= '0;
         idle_cnt_q <= '0;
         wait_cnt_q <= '0;
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         eof_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         hit_cnt_q  <= hit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
         busy_q     <= (state_d != S_IDLE);
         eof_q      <= (state_d == S_EOF);
      end
   end

   assign busy        = busy_q;
   assign active_ch   = sel_q;
   assign le_eof      = eof_q;
   assign err_timeout = err_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_lsf_input_scheduler.sv
// Randomized bench for lsf_input_scheduler: channel FIFOs are queues, the engine is
// random, and each event is checked against its expected timeline of transfers.
`timescale 1ns/1ps
module tb_lsf_input_scheduler;

   localparam int N_CH           = 3;
   localparam int CH_W           = 2;
   localparam int ROI_W          = 32;
   localparam int HIT_W          = 32;
   localparam int MAX_HITS       = 32;
   localparam int HIT_TIMEOUT    = 16;
   localparam int RESULT_TIMEOUT = 255;
   localparam int N_CYCLES       = 24000;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [N_CH*ROI_W-1:0] ch_roi;
   logic [N_CH-1:0]       ch_roi_empty, ch_roi_re;
   logic [N_CH*HIT_W-1:0] ch_hit;
   logic [N_CH-1:0]       ch_hit_empty, ch_hit_re;
   logic [ROI_W-1:0]      le_roi;
   logic [HIT_W-1:0]      le_hit;
   logic                  le_roi_empty, le_roi_re, le_hit_empty, le_hit_re;
   logic                  le_eof, le_output_vld, busy, err_timeout;
   logic [CH_W-1:0]       active_ch;
   logic [15:0]           drop_cnt;

   always #5 clock = ~clock;

   lsf_input_scheduler #(
      .N_CH(N_CH), .ROI_W(ROI_W), .HIT_W(HIT_W), .MAX_HITS(MAX_HITS),
      .HIT_TIMEOUT(HIT_TIMEOUT), .RESULT_TIMEOUT(RESULT_TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .ch_roi(ch_roi), .ch_roi_empty(ch_roi_empty), .ch_roi_re(ch_roi_re),
      .ch_hit(ch_hit), .ch_hit_empty(ch_hit_empty), .ch_hit_re(ch_hit_re),
      .le_roi(le_roi), .le_roi_empty(le_roi_empty), .le_roi_re(le_roi_re),
      .le_hit(le_hit), .le_hit_empty(le_hit_empty), .le_hit_re(le_hit_re),
      .le_eof(le_eof), .le_output_vld(le_output_vld), .busy(busy),
      .active_ch(active_ch), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
   );

   logic [ROI_W-1:0] roiQ [N_CH][$];
   logic [HIT_W-1:0] hitQ [N_CH][$];
   int               nLoaded [N_CH];
   logic [N_CH-1:0]  popRoi, popHit;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Event timeline model: who owns the engine, what it has moved, and when.
   bit evActive, roiDone, didReset;
   int curCh, rrPtr, expActive, fwd, drp, dropTotal, emptyRun;
   int eofCycle, vldOffset, toCycle, evNum, evDone, toExp, toSeen;
   int leftCh, leftCnt, flushCycle;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h",
                  tag, cyc, observed, expected);
      end
   endtask

   task automatic driveHeads();
      for (int c = 0; c < N_CH; c++) begin
         ch_roi_empty[c] = (roiQ[c].size() == 0);
         ch_hit_empty[c] = (hitQ[c].size() == 0);
         ch_roi[c*ROI_W +: ROI_W] = (roiQ[c].size() != 0) ? roiQ[c][0] : ROI_W'($urandom);
         ch_hit[c*HIT_W +: HIT_W] = (hitQ[c].size() != 0) ? hitQ[c][0] : HIT_W'($urandom);
      end
   endtask

   task automatic pushEvent(input int c);
      int n;
      int r;
      r = $urandom_range(7);
      if (r == 0)      n = 0;
      else if (r == 1) n = $urandom_range(40, 33);
      else if (r == 2) n = MAX_HITS;
      else             n = $urandom_range(12, 1);
      roiQ[c].push_back(ROI_W'($urandom));
      for (int i = 0; i < n; i++) hitQ[c].push_back(HIT_W'($urandom));
      nLoaded[c] = n;
   endtask

   function automatic bit waitingResult();
      return evActive && (eofCycle >= 0) && (cyc > eofCycle);
   endfunction

   // Engine behaviour for this cycle, plus one reset three hits into an event.
   task automatic applyStimulus();
      reset     = 1'b0;
      le_roi_re = ($urandom_range(3) != 0);
      le_hit_re = ($urandom_range(3) != 0);
      if (waitingResult()) le_output_vld = ((cyc - eofCycle - 1) == vldOffset);
      else                 le_output_vld = ($urandom_range(31) == 0);
      if (!didReset && evActive && roiDone && eofCycle < 0 && fwd >= 3 &&
          fwd < MAX_HITS && hitQ[curCh].size() != 0) begin
         reset    = 1'b1;
         didReset = 1'b1;
      end
   endtask

   task automatic checkCycle();
      logic [N_CH-1:0] oneHot, expRoiRe, expHitRe;
      logic            expRoiEmpty, expHitEmpty, expEof;
      int              expF, expD, k, c;
      bit              granted;
      oneHot = evActive ? N_CH'(1 << curCh) : '0;
      expEof = evActive && roiDone && (eofCycle < 0) && (emptyRun == HIT_TIMEOUT);
      checkOutput("busy", busy, evActive);
      checkOutput("active_ch", active_ch, expActive);
      checkOutput("drop_cnt", drop_cnt, dropTotal);
      checkOutput("err_timeout", err_timeout, cyc == toCycle);
      checkOutput("le_eof", le_eof, expEof);
      if (cyc == toCycle) toExp++;
      if (err_timeout) toSeen++;

      expRoiRe = '0; expHitRe = '0; expRoiEmpty = 1'b1; expHitEmpty = 1'b1;
      if (reset) begin
         checkOutput("ch_roi_re_in_reset", ch_roi_re, '0);
         checkOutput("ch_hit_re_in_reset", ch_hit_re, '0);
         leftCh = curCh; leftCnt = hitQ[curCh].size(); flushCycle = cyc + 30;
         evActive = 1'b0; rrPtr = 0; expActive = 0; dropTotal = 0; toCycle = -1;
         return;
      end

      if (!evActive) begin
         granted = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            c = (rrPtr + i) % N_CH;
            if (!granted && roiQ[c].size() != 0) begin
               granted = 1'b1; evActive = 1'b1; curCh = c; expActive = c;
               roiDone = 1'b0; eofCycle = -1; evNum++;
            end
         end
      end else if (!roiDone) begin
         expRoiEmpty = 1'b0;
         checkOutput("le_roi", le_roi, roiQ[curCh][0]);
         if (le_roi_re) begin
            expRoiRe = oneHot; roiDone = 1'b1; emptyRun = 0; fwd = 0; drp = 0;
            popRoi[curCh] = 1'b1;
         end
      end else if (eofCycle < 0) begin
         if (expEof) begin
            eofCycle = cyc; evDone++;
            expF = (nLoaded[curCh] < MAX_HITS) ? nLoaded[curCh] : MAX_HITS;
            expD = nLoaded[curCh] - expF;
            checkOutput("hits_forwarded", fwd, expF);
            checkOutput("hits_dropped", drp, expD);
            checkOutput("hits_left_in_fifo", hitQ[curCh].size(), 0);
            if (evNum % 9 == 4)      vldOffset = -1;
            else if (evNum % 9 == 7) vldOffset = RESULT_TIMEOUT;
            else                     vldOffset = $urandom_range(15);
         end else if (hitQ[curCh].size() == 0) begin
            emptyRun++;
         end else if (fwd < MAX_HITS) begin
            expHitEmpty = 1'b0;
            checkOutput("le_hit", le_hit, hitQ[curCh][0]);
            if (le_hit_re) begin
               expHitRe = oneHot; fwd++; emptyRun = 0; popHit[curCh] = 1'b1;
            end
         end else begin
            expHitRe = oneHot; drp++; emptyRun = 0; popHit[curCh] = 1'b1;
            if (dropTotal < 65535) dropTotal++;
         end
      end else begin
         k = cyc - eofCycle - 1;
         if (le_output_vld) begin
            evActive = 1'b0; rrPtr = (curCh + 1) % N_CH;
         end else if (k == RESULT_TIMEOUT) begin
            evActive = 1'b0; rrPtr = (curCh + 1) % N_CH; toCycle = cyc + 1;
         end
      end

      checkOutput("ch_roi_re", ch_roi_re, expRoiRe);
      checkOutput("ch_hit_re", ch_hit_re, expHitRe);
      checkOutput("le_roi_empty", le_roi_empty, expRoiEmpty);
      checkOutput("le_hit_empty", le_hit_empty, expHitEmpty);
   endtask

   // FIFO side after the clock edge: apply reads, occasionally queue a new event.
   task automatic advanceModel();
      int c;
      cyc++;
      for (int i = 0; i < N_CH; i++) begin
         if (popRoi[i]) void'(roiQ[i].pop_front());
         if (popHit[i]) void'(hitQ[i].pop_front());
      end
      popRoi = '0;
      popHit = '0;
      if (cyc == flushCycle) begin
         checkOutput("unread_hits_after_reset", hitQ[leftCh].size(), leftCnt);
         hitQ[leftCh].delete();
      end
      if ($urandom_range(5) == 0) begin
         c = $urandom_range(N_CH - 1);
         if (!(evActive && c == curCh) && roiQ[c].size() == 0 && hitQ[c].size() == 0)
            pushEvent(c);
      end
      driveHeads();
   endtask

   initial begin
      reset = 1'b1; le_roi_re = 1'b0; le_hit_re = 1'b0; le_output_vld = 1'b0;
      popRoi = '0; popHit = '0;
      evActive = 1'b0; roiDone = 1'b0; didReset = 1'b0;
      curCh = 0; rrPtr = 0; expActive = 0; fwd = 0; drp = 0; dropTotal = 0;
      emptyRun = 0; eofCycle = -1; vldOffset = 0; toCycle = -1;
      evNum = 0; evDone = 0; toExp = 0; toSeen = 0;
      leftCh = 0; leftCnt = 0; flushCycle = -1;
      driveHeads();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_active_ch", active_ch, '0);
      checkOutput("reset_le_eof", le_eof, 1'b0);
      checkOutput("reset_err_timeout", err_timeout, 1'b0);
      checkOutput("reset_drop_cnt", drop_cnt, '0);
      checkOutput("reset_ch_roi_re", ch_roi_re, '0);
      checkOutput("reset_ch_hit_re", ch_hit_re, '0);
      checkOutput("reset_le_roi_empty", le_roi_empty, 1'b1);
      checkOutput("reset_le_hit_empty", le_hit_empty, 1'b1);
      @(posedge clock);
      #1;
      for (int c = 0; c < N_CH; c++) pushEvent(c);
      driveHeads();

      for (int i = 0; i < N_CYCLES; i++) begin
         @(negedge clock);
         applyStimulus();
         #1;
         checkCycle();
         @(posedge clock);
         #1;
         advanceModel();
      end

      checkOutput("events_completed", evDone > 20, 1'b1);
      checkOutput("timeout_pulses", toSeen, toExp);
      checkOutput("mid_event_reset_exercised", didReset, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
